spw_tx_char_scheduler: RTL
==========================

# spw_tx_char_scheduler

Character scheduler for the SpaceWire transmitter (ECSS-E-ST-50-12C). Owns the one-hot `state_tx` bus that drives the TX bit counter and encoder. At every character boundary it picks the next character by standard priority: time-code > FCT > N-char > NULL. It also tracks the transmit credit granted by the far end and the number of FCTs owed to it, and double-buffers N-chars across two encoder buffers.

## Interface
Parameters:
- `MAX_CREDIT`, 56: credit ceiling in N-chars; multiple of 8.
- `MAX_FCT_OWED`, 7: saturation limit of the owed-FCT counter.

Ports:
- `pclk_tx` in 1: transmit clock, the only clock.
- `reset_tx` in 1: synchronous, active-high reset.
- `enable_tx` in 1: link enable; low = synchronous functional clear (see Operation).
- `send_null_tx` in 1: link FSM permits NULLs.
- `send_fct_tx` in 1: link FSM permits FCTs.
- `send_data_tx` in 1: link FSM in Run; N-chars and time-codes allowed.
- `char_done` in 1: one-cycle pulse on the last bit of the current character.
- `fct_rx` in 1: FCT received from far end; grants 8 credits.
- `fct_req` in 1: local receiver freed 8 slots; one more FCT owed.
- `data_valid` in 1: N-char offered.
- `data_in` in 9: bit 8 = control flag (1 = EOP/EEP), bits 7:0 = payload.
- `data_ready` out 1: N-char accepted this cycle.
- `tick_tx` in 1: time-code request pulse.
- `timecode_in` in 8: time-code value, captured on `tick_tx`.
- `state_tx` out 7: one-hot character select, encoded as start=0000000, null=0000001, fct=0000010, null_c=0000100, fct_c=0001000, data_c=0010000, data_c_0=0100000, time_code_c=1000000.
- `tx_data_in` out 1: control flag of buffer 0.
- `tx_data_in_0` out 1: control flag of buffer 1.
- `tx_data_char` out 9: buffer 0 contents.
- `tx_data_char_0` out 9: buffer 1 contents.
- `tx_time_code` out 8: time-code being sent.
- `fct_sent` out 1: pulse when an FCT is scheduled.
- `credit_count` out 6: current credit.
- `credit_error` out 1: sticky credit overflow flag.

## Operation
- Reset state (`reset_tx`, or `enable_tx` low): every output is 0.
  - `state_tx` = start; credit = 0; owed FCTs = 0; tick pending clear; buffer select = 0; `credit_error` = 0.
- Leaving start: when `enable_tx` and `send_null_tx` are both high, the next edge loads `state_tx` = null.
- Decision point: each `char_done` while `state_tx` ≠ start.
- Selection at a decision point, first match wins:
  1. Tick pending and `send_data_tx`: time_code_c. Clears pending.
  2. Owed > 0 and `send_fct_tx`: fct_c if `send_data_tx`, else fct. Decrements owed; pulses `fct_sent`.
  3. `data_valid` and credit > 0 and `send_data_tx`: data_c if buffer select = 0, else data_c_0.
     - Loads `data_in` into the selected buffer.
     - Pulses `data_ready`, decrements credit, toggles buffer select.
  4. Otherwise: null_c if `send_data_tx`, else null.
- `send_null_tx` low at a decision point: return to start.
- Owed-FCT counter:
  - `fct_req` increments it, saturating at `MAX_FCT_OWED`.
  - `fct_req` in the same cycle as an FCT being scheduled leaves it unchanged.
- Credit counter:
  - `fct_rx` adds 8.
  - If credit + 8 would exceed `MAX_CREDIT`: set `credit_error`, credit unchanged.
  - `fct_rx` in the same cycle as an N-char decrement gives a net +7.
- Tick handling:
  - `tick_tx` sets pending and captures `timecode_in` into `tx_time_code`.
  - A tick arriving while pending overwrites the value.
  - A tick coincident with time-code selection leaves pending set, holding the new value.
- `credit_error` clears only via reset or `enable_tx` low.

## Timing
- `state_tx` changes on the edge after `char_done`. Latency is 1 cycle.
- `state_tx` is stable between decision points.
- `data_ready` is combinational from registered state, `char_done`, `data_valid` and `send_data_tx`, in the `char_done` cycle. Accept = `data_valid` & `data_ready`.
- Buffer load, credit decrement and `fct_sent` take effect on the same edge as the `state_tx` update.
- `enable_tx` low: clear on the next edge; this overrides a simultaneous `char_done`.

## Configuration
- `SPW_TX_TIMECODE_EN` defined: time-code path as described.
- Not defined:
  - `tick_tx` and `timecode_in` are ignored; no pending register.
  - `tx_time_code` is tied to 0.
  - time_code_c is never issued; priority starts at FCT.

## Test plan
- Bring-up:
  - Stimulus: reset, then `enable_tx`=1 and `send_null_tx`=1, `char_done` every 8 cycles.
  - Expect: `state_tx`=0000001 one cycle after enable, NULL repeated, `credit_count`=0.
- FCT phase:
  - Stimulus: `send_fct_tx`=1, three `fct_req` pulses.
  - Expect: next three decisions give 0000010 with `fct_sent` pulses, then 0000001.
- Run with credit:
  - Stimulus: `send_data_tx`=1, one `fct_rx`, `data_valid` held with data_in=0x041 then 0x142.
  - Expect: data_c/`tx_data_char`=0x041 and `tx_data_in`=0, then data_c_0/`tx_data_char_0`=0x142 and `tx_data_in_0`=1.
  - After 8 accepts credit=0 and null_c follows.
- Priority:
  - Stimulus: `tick_tx` with value 0x2A, one owed FCT and valid data, all pending at one `char_done`.
  - Expect: order time_code_c (`tx_time_code`=0x2A), then fct_c, then data_c.
- Credit overflow:
  - Stimulus: eight `fct_rx` pulses.
  - Expect: credit 56 after seven; eighth sets `credit_error`=1 with credit=56.
  - `fct_rx` coincident with a data accept at credit 10 gives 17.
- Mid-operation clear:
  - Stimulus: `enable_tx`=0 during data_c together with `char_done`.
  - Expect: next cycle `state_tx`=0, credit=0, owed=0, `credit_error`=0, `data_ready`=0.

Source files
------------

// File: rtl/spw_tx_char_scheduler.sv
// ============================================================================
// Module  : spw_tx_char_scheduler
// Purpose : SpaceWire TX character scheduler (time-code > FCT > N-char > NULL).
//           Optional time-code path enabled by defining SPW_TX_TIMECODE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spw_tx_char_scheduler #(
  parameter int MAX_CREDIT   = 56,
  parameter int MAX_FCT_OWED = 7
) (
  input  logic       pclk_tx,
  input  logic       reset_tx,
  input  logic       enable_tx,
  input  logic       send_null_tx,
  input  logic       send_fct_tx,
  input  logic       send_data_tx,
  input  logic       char_done,
  input  logic       fct_rx,
  input  logic       fct_req,
  input  logic       data_valid,
  input  logic [8:0] data_in,
  output logic       data_ready,
  input  logic       tick_tx,
  input  logic [7:0] timecode_in,
  output logic [6:0] state_tx,
  output logic       tx_data_in,
  output logic       tx_data_in_0,
  output logic [8:0] tx_data_char,
  output logic [8:0] tx_data_char_0,
  output logic [7:0] tx_time_code,
  output logic       fct_sent,
  output logic [5:0] credit_count,
  output logic       credit_error
);

  localparam int OWED_W = $clog2(MAX_FCT_OWED + 1);
  localparam logic [OWED_W-1:0] OWED_MAX = OWED_W'(MAX_FCT_OWED);

  typedef enum logic [6:0] {
    S_START   = 7'b0000000,
    S_NULL    = 7'b0000001,
    S_FCT     = 7'b0000010,
    S_NULL_C  = 7'b0000100,
    S_FCT_C   = 7'b0001000,
    S_DATA_C  = 7'b0010000,
    S_DATA_C0 = 7'b0100000,
    S_TC      = 7'b1000000
  } state_t;

  state_t            state;
  logic [OWED_W-1:0] owed;
  logic [5:0]        credit;
  logic              err;
  logic              buf_sel;
  logic [8:0]        buf0;
  logic [8:0]        buf1;
  logic              fct_sent_r;

  logic              decide;
  logic              sel_tc;
  logic              sel_fct;
  logic              sel_data;
  logic              take_tc;
  logic              take_fct;
  logic              take_data;
  logic [6:0]        credit_plus8;
  logic              credit_ovf;

`ifdef SPW_TX_TIMECODE_EN
  logic              tick_pend;
  logic [7:0]        tcode;
  assign sel_tc       = tick_pend & send_data_tx;
  assign tx_time_code = tcode;
`else
  logic              unused_tc;
  assign unused_tc    = ^{tick_tx, timecode_in};
  assign sel_tc       = 1'b0;
  assign tx_time_code = 8'd0;
`endif

  // A decision only counts when the link stays enabled and NULLs remain allowed
  assign decide    = enable_tx & char_done & (state != S_START) & send_null_tx;
  assign sel_fct   = (owed != '0) & send_fct_tx;
  assign sel_data  = data_valid & (credit != '0) & send_data_tx;
  assign take_tc   = decide & sel_tc;
  assign take_fct  = decide & ~sel_tc & sel_fct;
  assign take_data = decide & ~sel_tc & ~sel_fct & sel_data;
  assign data_ready = take_data;

  assign credit_plus8 = {1'b0, credit} + 7'd8;
  assign credit_ovf   = credit_plus8 > 7'(MAX_CREDIT);

  always_ff @(posedge pclk_tx) begin
    if (reset_tx || !enable_tx) begin
      state      <= S_START;
      owed       <= '0;
      credit     <= '0;
      err        <= 1'b0;
      buf_sel    <= 1'b0;
      buf0       <= '0;
      buf1       <= '0;
      fct_sent_r <= 1'b0;
`ifdef SPW_TX_TIMECODE_EN
      tick_pend  <= 1'b0;
      tcode      <= '0;
`endif
    end else begin
      fct_sent_r <= take_fct;

      if (state == S_START) begin
        if (send_null_tx) state <= S_NULL;
      end else if (char_done) begin
        if (!send_null_tx)  state <= S_START;
        else if (take_tc)   state <= S_TC;
        else if (take_fct)  state <= send_data_tx ? S_FCT_C : S_FCT;
        else if (take_data) state <= buf_sel ? S_DATA_C0 : S_DATA_C;
        else                state <= send_data_tx ? S_NULL_C : S_NULL;
      end

      if (take_data) begin
        if (buf_sel) buf1 <= data_in;
        else         buf0 <= data_in;
        buf_sel <= ~buf_sel;
      end

      // A request coincident with an FCT going out cancels against it
      if (take_fct && !fct_req)
        owed <= owed - 1'b1;
      else if (!take_fct && fct_req && owed != OWED_MAX)
        owed <= owed + 1'b1;

      case ({fct_rx & ~credit_ovf, take_data})
        2'b10:   credit <= credit + 6'd8;
        2'b01:   credit <= credit - 6'd1;
        2'b11:   credit <= credit + 6'd7;
        default: credit <= credit;
      endcase
      if (fct_rx && credit_ovf) err <= 1'b1;

`ifdef SPW_TX_TIMECODE_EN
      // A new tick wins over the clear so a back-to-back tick is not lost
      if (tick_tx) begin
        tick_pend <= 1'b1;
        tcode     <= timecode_in;
      end else if (take_tc) begin
        tick_pend <= 1'b0;
      end
`endif
    end
  end

  assign state_tx       = state;
  assign tx_data_char   = buf0;
  assign tx_data_char_0 = buf1;
  assign tx_data_in     = buf0[8];
  assign tx_data_in_0   = buf1[8];
  assign credit_count   = credit;
  assign credit_error   = err;
  assign fct_sent       = fct_sent_r;

endmodule

`default_nettype wire
